fft_power_integrator: RTL and testbench

Parametrised successor to the FFT-output power stage. Computes per-lane |X|² = re² + im² for LANES complex bins per vector, with round-half-up LSB truncation and MSB saturation. Adds a runtime-selectable integration mode that accumulates power per bin index across cfg_frames FFT frames in an internal per-bin RAM. Sits between the FFT output reorder buffer and the detection/threshold logic.

---
 rtl/fft_power_pkg.sv | 49 ++++
 rtl/fft_power_if.sv | 30 +++
 rtl/fft_lane_power.sv | 40 ++++
 rtl/fft_power_integrator.sv | 168 ++++++++++++++++
 tb/tb_fft_power_integrator.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/fft_power_pkg.sv
// Shared widths, types and arithmetic helpers for the FFT power stage.
// Data widths are fixed here; lane count and index width are top parameters.
package fft_power_pkg;

  localparam int IN_W    = 32;
  localparam int OUT_W   = 52;
  localparam int LSB_CUT = 11;
  localparam int PROD_W  = 2*IN_W;
  localparam int SUM_W   = 2*IN_W + 1;
  localparam int RND_W   = SUM_W - LSB_CUT + 1;

  typedef enum logic {
    MODE_INST  = 1'b0,
    MODE_INTEG = 1'b1
  } mode_e;

  typedef logic [OUT_W-1:0] pwr_t;

  typedef struct packed {
    logic sat;
    pwr_t val;
  } pwr_sat_t;

  typedef struct packed {
    logic wr;
    logic acc;
    logic emit;
    logic wend;
  } ctl_t;

  function automatic pwr_sat_t round_sat(input logic [SUM_W-1:0] sum);
    logic [RND_W-1:0] r;
    pwr_sat_t o;
    r = RND_W'(sum >> LSB_CUT) + RND_W'(sum[LSB_CUT-1]);
    o.sat = |r[RND_W-1:OUT_W];
    o.val = o.sat ? '1 : r[OUT_W-1:0];
    return o;
  endfunction

  function automatic pwr_sat_t sat_add(input pwr_t a, input pwr_t b);
    logic [OUT_W:0] s;
    pwr_sat_t o;
    s = {1'b0, a} + {1'b0, b};
    o.sat = s[OUT_W];
    o.val = s[OUT_W] ? '1 : s[OUT_W-1:0];
    return o;
  endfunction

endpackage

// File: rtl/fft_power_if.sv
// Input vector and output power bus of the FFT power stage.
// master drives vectors in, slave is the power stage itself.
interface fft_power_if
  import fft_power_pkg::*;
#(
  parameter int LANES = 4,
  parameter int IDX_W = 11
);

  logic                   in_valid;
  logic                   in_last;
  logic [IDX_W-1:0]       in_index;
  logic [LANES*IN_W-1:0]  in_re;
  logic [LANES*IN_W-1:0]  in_im;
  logic                   out_valid;
  logic [IDX_W-1:0]       out_index;
  logic [LANES*OUT_W-1:0] out_power;
  logic                   out_window_end;

  modport master (
    output in_valid, in_last, in_index, in_re, in_im,
    input  out_valid, out_index, out_power, out_window_end
  );

  modport slave (
    input  in_valid, in_last, in_index, in_re, in_im,
    output out_valid, out_index, out_power, out_window_end
  );

endinterface

// File: rtl/fft_lane_power.sv
// One lane: squares in S2, sum in S3, round/saturate combinationally for S4.
// Registers only advance on a valid stage so idle cycles leave data intact.
module fft_lane_power
  import fft_power_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s1_valid,
  input  logic                    s2_valid,
  input  logic signed [IN_W-1:0]  re,
  input  logic signed [IN_W-1:0]  im,
  output pwr_sat_t                pwr
);

  logic signed [PROD_W-1:0] re_sq;
  logic signed [PROD_W-1:0] im_sq;
  logic [SUM_W-1:0]         sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      re_sq <= '0;
      im_sq <= '0;
    end else if (s1_valid) begin
      re_sq <= PROD_W'(re) * PROD_W'(re);
      im_sq <= PROD_W'(im) * PROD_W'(im);
    end
  end

  // squares are never negative, so the sum is taken unsigned
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
    end else if (s2_valid) begin
      sum <= {1'b0, re_sq} + {1'b0, im_sq};
    end
  end

  assign pwr = round_sat(sum);

endmodule

// File: rtl/fft_power_integrator.sv
// Per-lane |X|^2 with optional multi-frame integration per bin index.
// Four-stage pipeline; RAM read in S2/S3, read-modify-write closes in S4.
module fft_power_integrator
  import fft_power_pkg::*;
#(
  parameter int LANES = 4,
  parameter int IDX_W = 11,
  parameter int FRM_W = 8
)(
  input  logic             clk,
  input  logic             rst_n,
  fft_power_if.slave       bus,
  input  logic             cfg_mode,
  input  logic [FRM_W-1:0] cfg_frames,
  input  logic             cfg_clear,
  output logic             sat_sticky,
  output logic [FRM_W-1:0] frame_cnt
);

  localparam int DEPTH = 2**IDX_W;
  localparam int VEC_W = LANES*OUT_W;

  logic             win_first;
  mode_e            lat_mode;
  logic [FRM_W-1:0] lat_n;
  mode_e            eff_mode;
  logic [FRM_W-1:0] eff_n;
  logic             integ;
  logic             last_fr;
  ctl_t             in_ctl;

  // first vector of a window takes config live, later ones use the latch
  always_comb begin
    eff_mode = win_first ? mode_e'(cfg_mode) : lat_mode;
    eff_n    = lat_n;
    if (win_first)
      eff_n = (cfg_frames == '0) ? FRM_W'(1) : cfg_frames;
    integ    = (eff_mode == MODE_INTEG) && (eff_n != FRM_W'(1));
    last_fr  = !integ || (frame_cnt == eff_n - FRM_W'(1));
    in_ctl.wr   = integ && !last_fr;
    in_ctl.acc  = integ && (frame_cnt != '0);
    in_ctl.emit = last_fr;
    in_ctl.wend = bus.in_last && last_fr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_first <= 1'b1;
      lat_mode  <= MODE_INST;
      lat_n     <= FRM_W'(1);
      frame_cnt <= '0;
    end else if (bus.in_valid) begin
      if (win_first) begin
        lat_mode <= eff_mode;
        lat_n    <= eff_n;
      end
      win_first <= bus.in_last && last_fr;
      if (bus.in_last)
        frame_cnt <= last_fr ? '0 : frame_cnt + FRM_W'(1);
    end
  end

  logic                  s1_valid, s2_valid, s3_valid;
  logic [IDX_W-1:0]      s1_idx, s2_idx, s3_idx;
  ctl_t                  s1_ctl, s2_ctl, s3_ctl;
  logic [LANES*IN_W-1:0] s1_re, s1_im;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
    end else begin
      s1_valid <= bus.in_valid;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_idx <= '0;
      s1_ctl <= '0;
      s1_re  <= '0;
      s1_im  <= '0;
      s2_idx <= '0;
      s2_ctl <= '0;
      s3_idx <= '0;
      s3_ctl <= '0;
    end else begin
      if (bus.in_valid) begin
        s1_idx <= bus.in_index;
        s1_ctl <= in_ctl;
        s1_re  <= bus.in_re;
        s1_im  <= bus.in_im;
      end
      if (s1_valid) begin
        s2_idx <= s1_idx;
        s2_ctl <= s1_ctl;
      end
      if (s2_valid) begin
        s3_idx <= s2_idx;
        s3_ctl <= s2_ctl;
      end
    end
  end

  pwr_sat_t lane_pwr [LANES];

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    fft_lane_power u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .s1_valid (s1_valid),
      .s2_valid (s2_valid),
      .re       (s1_re[g*IN_W +: IN_W]),
      .im       (s1_im[g*IN_W +: IN_W]),
      .pwr      (lane_pwr[g])
    );
  end

  logic [VEC_W-1:0] mem [DEPTH];
  logic [VEC_W-1:0] ram_q;
  logic [VEC_W-1:0] acc_vec;
  logic [LANES-1:0] lane_sat;
  pwr_sat_t         add_r;

  always_comb begin
    acc_vec  = '0;
    lane_sat = '0;
    add_r    = '0;
    for (int i = 0; i < LANES; i++) begin
      add_r = sat_add(ram_q[i*OUT_W +: OUT_W], lane_pwr[i].val);
      acc_vec[i*OUT_W +: OUT_W] = s3_ctl.acc ? add_r.val : lane_pwr[i].val;
      lane_sat[i] = lane_pwr[i].sat | (s3_ctl.acc & add_r.sat);
    end
  end

  // contents are never reset: frame 0 of every window overwrites them
  always_ff @(posedge clk) begin
    if (s3_valid && s3_ctl.wr)
      mem[s3_idx] <= acc_vec;
    if (s2_valid)
      ram_q <= mem[s2_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid      <= 1'b0;
      bus.out_window_end <= 1'b0;
      bus.out_index      <= '0;
      bus.out_power      <= '0;
      sat_sticky         <= 1'b0;
    end else begin
      bus.out_valid      <= s3_valid && s3_ctl.emit;
      bus.out_window_end <= s3_valid && s3_ctl.emit && s3_ctl.wend;
      if (s3_valid && s3_ctl.emit) begin
        bus.out_index <= s3_idx;
        bus.out_power <= acc_vec;
      end
      if (s3_valid && |lane_sat)
        sat_sticky <= 1'b1;
      else if (cfg_clear)
        sat_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_power_integrator.sv
// Scoreboard bench for fft_power_integrator: directed vectors, queued
// expectations, and an independent output monitor.
module tb_fft_power_integrator;
  import fft_power_pkg::*;

  localparam int LANES = 4;
  localparam int IDX_W = 11;
  localparam int FRM_W = 8;
  localparam int VW    = LANES*OUT_W;
  localparam int DW    = LANES*IN_W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_mode = 1'b0;
  logic [FRM_W-1:0] cfg_frames = '0;
  logic             cfg_clear = 1'b0;
  logic             sat_sticky;
  logic [FRM_W-1:0] frame_cnt;

  fft_power_if #(.LANES(LANES), .IDX_W(IDX_W)) bus ();

  fft_power_integrator #(.LANES(LANES), .IDX_W(IDX_W), .FRM_W(FRM_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .cfg_mode   (cfg_mode),
    .cfg_frames (cfg_frames),
    .cfg_clear  (cfg_clear),
    .sat_sticky (sat_sticky),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_tot  = 0;

  typedef struct {
    int               due;
    logic [IDX_W-1:0] idx;
    logic [VW-1:0]    pw;
    logic             wend;
  } exp_t;

  exp_t sbq[$];

  logic [2**IDX_W-1:0] seen = '0;
  int                  fcount = 0;

  task automatic check(input string name, input logic [VW-1:0] act,
                       input logic [VW-1:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.out_valid) begin
      check("sb_nonempty", VW'(sbq.size() != 0), VW'(1));
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        check("latency", VW'(cyc), VW'(e.due));
        check("out_index", VW'(bus.out_index), VW'(e.idx));
        check("out_power", bus.out_power, e.pw);
        check("window_end", VW'(bus.out_window_end), VW'(e.wend));
      end
    end
  end

  task automatic send(input int idx, input bit last,
                      input logic [DW-1:0] re, input logic [DW-1:0] im,
                      input bit emit, input logic [VW-1:0] pw);
    exp_t e;
    assert (!seen[idx]) else $error("hazard: index %0d repeated", idx);
    seen[idx] = 1'b1;
    fcount++;
    if (last) begin
      assert (fcount >= 3) else $error("hazard: frame too short");
      seen   = '0;
      fcount = 0;
    end
    bus.in_valid = 1'b1;
    bus.in_last  = last;
    bus.in_index = IDX_W'(idx);
    bus.in_re    = re;
    bus.in_im    = im;
    if (emit) begin
      e.due  = cyc + 4;
      e.idx  = IDX_W'(idx);
      e.pw   = pw;
      e.wend = last;
      sbq.push_back(e);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic frame(input int n, input logic [DW-1:0] re,
                       input bit emit, input logic [VW-1:0] pw);
    for (int i = 0; i < n; i++)
      send(i, i == n-1, re, '0, emit, pw);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sbq.size() != 0; i++)
      @(negedge clk);
    check("sb_drained", VW'(sbq.size()), VW'(0));
  endtask

  logic [DW-1:0] re_mix, im_mix, re64, re128, sat_v;
  logic [VW-1:0] p_mix, ones, p6, p10;

  initial begin
    re_mix = {32'd30, 32'd32, 32'd32, 32'd64};
    im_mix = {32'd10, 32'd0,  32'd32, 32'd0};
    p_mix  = {52'd0,  52'd1,  52'd1,  52'd2};
    re64   = {LANES{32'd64}};
    re128  = {LANES{32'd128}};
    sat_v  = {LANES{32'h8000_0000}};
    ones   = '1;
    p6     = {LANES{52'd6}};
    p10    = {LANES{52'd10}};

    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_index = '0;
    bus.in_re    = '0;
    bus.in_im    = '0;

    repeat (3) @(negedge clk);
    check("rst_out_valid", VW'(bus.out_valid), VW'(0));
    check("rst_out_power", bus.out_power, '0);
    check("rst_frame_cnt", VW'(frame_cnt), VW'(0));
    check("rst_sat", VW'(sat_sticky), VW'(0));
    rst_n = 1'b1;
    @(negedge clk);

    cfg_mode   = 1'b0;
    cfg_frames = 8'd1;
    send(5, 1'b0, re_mix, im_mix, 1'b1, p_mix);
    send(6, 1'b0, sat_v, sat_v, 1'b1, ones);
    send(7, 1'b1, '0, '0, 1'b1, '0);
    repeat (6) @(negedge clk);
    drain();
    check("m0_sat_sticky", VW'(sat_sticky), VW'(1));
    check("m0_frame_cnt", VW'(frame_cnt), VW'(0));
    cfg_clear = 1'b1;
    @(negedge clk);
    cfg_clear = 1'b0;
    check("clear_sticky", VW'(sat_sticky), VW'(0));

    cfg_mode   = 1'b1;
    cfg_frames = 8'd3;
    frame(8, re64, 1'b0, '0);
    check("w3_fc_a", VW'(frame_cnt), VW'(1));
    cfg_frames = 8'd5;
    frame(8, re64, 1'b0, '0);
    check("w3_fc_b", VW'(frame_cnt), VW'(2));
    frame(8, re64, 1'b1, p6);
    check("w3_fc_wrap", VW'(frame_cnt), VW'(0));
    for (int f = 0; f < 4; f++) begin
      frame(8, re64, 1'b0, '0);
      check("w5_fc", VW'(frame_cnt), VW'(f + 1));
    end
    frame(8, re64, 1'b1, p10);
    check("w5_fc_wrap", VW'(frame_cnt), VW'(0));
    drain();

    cfg_frames = 8'd2;
    frame(3, sat_v, 1'b0, '0);
    repeat (5) @(negedge clk);
    check("acc_f0_sticky", VW'(sat_sticky), VW'(0));
    frame(3, sat_v, 1'b1, ones);
    drain();
    check("acc_sat_sticky", VW'(sat_sticky), VW'(1));

    cfg_frames = 8'd3;
    frame(8, re128, 1'b0, '0);
    send(0, 1'b0, re128, '0, 1'b0, '0);
    send(1, 1'b0, re128, '0, 1'b0, '0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", VW'(bus.out_valid), VW'(0));
    check("mid_rst_power", bus.out_power, '0);
    check("mid_rst_fc", VW'(frame_cnt), VW'(0));
    check("mid_rst_sat", VW'(sat_sticky), VW'(0));
    seen   = '0;
    fcount = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    frame(8, re64, 1'b0, '0);
    frame(8, re64, 1'b0, '0);
    frame(8, re64, 1'b1, p6);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
